// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side drain engine for an asynchronous FIFO, clocked in the read domain.
//   Pops words with fifo_rd_en, absorbs the FIFO's one-cycle read latency and
//   presents the words as a valid/ready stream through a 2-entry skid buffer.
//   It sustains one word per cycle while the FIFO is non-empty and the sink is ready.
//
// Ports
//   rd_clk        read-domain clock (posedge)
//   rd_rst        asynchronous active-high reset
//   en            0 stops new FIFO reads; buffered and in-flight words still drain
//   flush         1-cycle pulse; discards buffered and in-flight words
//   fifo_empty    FIFO empty flag
//   fifo_rd_data  FIFO read data, valid the cycle after an accepted fifo_rd_en
//   fifo_rd_en    FIFO pop request (combinational)
//   m_data        stream data (registered buffer head)
//   m_valid       stream valid
//   m_ready       stream ready from the sink
//   rd_count      words delivered (m_valid && m_ready), wraps modulo 2^CNT_W
//   busy          buffer not empty or a read is in flight
module fifo_rd_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             en,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] rd_count,
  output logic             busy
);

  logic             vld_p1;   // a FIFO read was accepted; its data is on fifo_rd_data now
  logic [1:0]       occ_p2;   // words held in the skid buffer (0..2)
  logic [WIDTH-1:0] tail_p2;  // second buffer entry; the head is m_data itself
  logic [1:0]       level;
  logic             pop;
  logic             push;
  logic             issue;

  assign pop   = m_valid && m_ready;
  assign push  = vld_p1 && !flush;
  assign level = occ_p2 + {1'b0, vld_p1};

  // A new read is allowed only if the word it brings will find a free slot:
  // either fewer than two words are committed, or one is leaving this cycle.
  assign issue = !rd_rst && en && !flush && !fifo_empty &&
                 ((level < 2'd2) || ((level == 2'd2) && pop));

  assign fifo_rd_en = issue;
  assign m_valid    = (occ_p2 != 2'd0);
  assign busy       = (occ_p2 != 2'd0) || vld_p1;

  // ---- stage p1: FIFO read in flight ----
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue;
    end
  end

  // ---- stage p2: skid buffer head, occupancy and delivery counter ----
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      occ_p2   <= 2'd0;
      m_data   <= '0;
      rd_count <= '0;
    end else begin
      if (pop) begin
        rd_count <= rd_count + CNT_W'(1);
      end
      if (flush) begin
        occ_p2 <= 2'd0;
      end else begin
        case ({push, pop})
          2'b10: begin
            occ_p2 <= occ_p2 + 2'd1;
            if (occ_p2 == 2'd0) begin
              m_data <= fifo_rd_data;
            end
          end
          2'b01: begin
            occ_p2 <= occ_p2 - 2'd1;
            m_data <= tail_p2;
          end
          2'b11: begin
            // Occupancy is unchanged; the head advances to the next-oldest word.
            m_data <= (occ_p2 == 2'd1) ? fifo_rd_data : tail_p2;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Tail entry carries data only; its contents are meaningless while occ_p2 < 2.
  always_ff @(posedge rd_clk) begin
    if (push && (((occ_p2 == 2'd1) && !pop) || ((occ_p2 == 2'd2) && pop))) begin
      tail_p2 <= fifo_rd_data;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rd_rst;
  logic        en;
  logic        flush;
  logic        m_ready;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_en;
  logic [7:0]  m_data;
  logic        m_valid;
  logic [15:0] rd_count;
  logic        busy;

  logic        fifo_rd_en4;
  logic [7:0]  m_data4;
  logic        m_valid4;
  logic [3:0]  rd_count4;
  logic        busy4;

  fifo_rd_stream #(.WIDTH(8), .CNT_W(16)) u_dut (
    .rd_clk(clk), .rd_rst(rd_rst), .en(en), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .rd_count(rd_count), .busy(busy)
  );

  // Narrow-counter instance fed identically; only its counter is of interest.
  fifo_rd_stream #(.WIDTH(8), .CNT_W(4)) u_dut4 (
    .rd_clk(clk), .rd_rst(rd_rst), .en(en), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en4),
    .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready),
    .rd_count(rd_count4), .busy(busy4)
  );

  // Behavioural FIFO: array plus pointers, data one cycle after an accepted pop.
  logic [7:0] mem [0:4095];
  int         rd_ptr = 0;
  int         wr_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  // Reference model: every word taken from the FIFO must be delivered once, in order,
  // unless a flush or reset discards it.
  logic [7:0] exp_q[$];
  bit         inflight = 1'b0;
  int         dcnt = 0;
  int         checks = 0;
  int         errors = 0;
  bit         hold_prev = 1'b0;
  logic [7:0] hold_data;

  always @(posedge clk) begin
    inflight <= 1'b0;
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= mem[rd_ptr];
      exp_q.push_back(mem[rd_ptr]);
      rd_ptr   <= rd_ptr + 1;
      inflight <= 1'b1;
    end
  end

  always @(negedge clk) begin
    int         buffered;
    logic [7:0] e;
    if (rd_rst) begin
      hold_prev = 1'b0;
    end else begin
      buffered = exp_q.size() - int'(inflight);
      checks++;
      if (buffered > 2 || buffered < 0) begin
        errors++;
        $display("FAIL occupancy: buffered=%0d required 0..2", buffered);
      end
      checks++;
      if (m_valid !== (buffered > 0)) begin
        errors++;
        $display("FAIL m_valid_model: got %b required %b", m_valid, (buffered > 0));
      end
      checks++;
      if (busy !== (exp_q.size() > 0)) begin
        errors++;
        $display("FAIL busy_model: got %b required %b", busy, (exp_q.size() > 0));
      end
      if (fifo_empty || flush) begin
        checks++;
        if (fifo_rd_en !== 1'b0) begin
          errors++;
          $display("FAIL rd_en_gate: got %b required 0 (empty=%b flush=%b)", fifo_rd_en, fifo_empty, flush);
        end
      end
      if (hold_prev) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== hold_data) begin
          errors++;
          $display("FAIL no_drop: got valid=%b data=%h required valid=1 data=%h", m_valid, m_data, hold_data);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL order: got data=%h required no delivery", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            errors++;
            $display("FAIL order: got data=%h required %h", m_data, e);
          end
        end
        dcnt++;
      end
      hold_prev = m_valid && !m_ready && !flush;
      hold_data = m_data;
      if (flush) exp_q.delete();
    end
  end

  task automatic push_word(input logic [7:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && fifo_empty && !m_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rd_rst = 1'b1; en = 1'b1; flush = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'($urandom));
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b required 0", fifo_rd_en); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
    checks++; if (rd_count !== 16'd0) begin errors++; $display("FAIL reset_rd_count: got %0d required 0", rd_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h required 00", m_data); end
    @(posedge clk); #1;
    en = 1'b0;
    wr_ptr = rd_ptr;
    rd_rst = 1'b0;
  endtask

  task automatic test_stream();
    int c0 = -1;
    int c1 = -1;
    int nv = 0;
    bit gap = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) push_word(8'(i));
    en = 1'b1; m_ready = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (fifo_rd_en && c0 < 0) c0 = cyc;
      if (m_valid) begin
        if (c1 < 0) c1 = cyc;
        if (nv < 32) begin
          checks++;
          if (m_data !== 8'(nv)) begin errors++; $display("FAIL stream_data: got %h required %h", m_data, 8'(nv)); end
        end
        nv++;
      end else if (c1 >= 0 && nv < 32) begin
        gap = 1'b1;
      end
    end
    checks++; if (c0 < 0 || c1 - c0 != 2) begin errors++; $display("FAIL stream_latency: got %0d cycles required 2", c1 - c0); end
    checks++; if (gap) begin errors++; $display("FAIL stream_bubble: got a gap required none"); end
    checks++; if (nv != 32) begin errors++; $display("FAIL stream_words: got %0d required 32", nv); end
    checks++; if (rd_count !== 16'd32) begin errors++; $display("FAIL stream_rd_count: got %0d required 32", rd_count); end
    checks++; if (rd_count4 !== 4'd0) begin errors++; $display("FAIL stream_rd_count4: got %0d required 0", rd_count4); end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    int  base = dcnt;
    bit  ok;
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) push_word(8'($urandom));
    en = 1'b1; m_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1; m_ready = 1'b0;
    held = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) held = m_data;
    end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en: got %b required 0", fifo_rd_en); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_m_valid: got %b required 1", m_valid); end
    checks++; if (m_data !== held) begin errors++; $display("FAIL bp_m_data: got %h required %h", m_data, held); end
    checks++; if (exp_q.size() != 2 || inflight) begin errors++; $display("FAIL bp_buffered: got %0d required 2", exp_q.size()); end
    @(posedge clk); #1; m_ready = 1'b1;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got busy required idle"); end
    checks++; if (rd_count !== 16'(base + 40)) begin errors++; $display("FAIL bp_rd_count: got %0d required %0d", rd_count, 16'(base + 40)); end
  endtask

  task automatic test_empty_boundary();
    int pops = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push_word(8'($urandom));
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid && m_ready) pops++;
      @(posedge clk); #1;
      m_ready = ~m_ready;
    end
    @(negedge clk);
    checks++; if (pops != 3) begin errors++; $display("FAIL empty_pops: got %0d required 3", pops); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL empty_m_valid: got %b required 0", m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy: got %b required 0", busy); end
  endtask

  task automatic test_flush();
    logic [7:0] w [0:19];
    bit ok;
    bit seen = 1'b0;
    @(posedge clk); #1;
    m_ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      w[i] = 8'($urandom);
      push_word(w[i]);
    end
    repeat (6) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_m_valid: got %b required 0", m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b required 0", busy); end
    checks++; if (rd_count !== 16'(dcnt)) begin errors++; $display("FAIL flush_rd_count: got %0d required %0d", rd_count, 16'(dcnt)); end
    @(posedge clk); #1; m_ready = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (m_valid) begin
        seen = 1'b1;
        checks++;
        if (m_data !== w[2]) begin errors++; $display("FAIL flush_next: got %h required %h", m_data, w[2]); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL flush_resume: got no valid required a word"); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL flush_timeout: got busy required idle"); end
  endtask

  task automatic test_random();
    bit ok;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      en      = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 2) == 0) push_word(8'($urandom));
    end
    @(posedge clk); #1;
    flush = 1'b0; en = 1'b1; m_ready = 1'b1;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_timeout: got busy required idle"); end
    checks++; if (rd_count !== 16'(dcnt)) begin errors++; $display("FAIL rand_rd_count: got %0d required %0d", rd_count, 16'(dcnt)); end
    checks++; if (rd_count4 !== 4'(dcnt)) begin errors++; $display("FAIL rand_rd_count4: got %0d required %0d", rd_count4, 4'(dcnt)); end
  endtask

  task automatic test_wrap_reset();
    bit ok;
    @(posedge clk); #1;
    for (int i = 0; i < 30; i++) push_word(8'($urandom));
    en = 1'b1; m_ready = 1'b1;
    repeat (5) @(posedge clk);
    #3; rd_rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL arst_m_valid: got %b required 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL arst_m_data: got %h required 00", m_data); end
    checks++; if (rd_count !== 16'd0) begin errors++; $display("FAIL arst_rd_count: got %0d required 0", rd_count); end
    checks++; if (rd_count4 !== 4'd0) begin errors++; $display("FAIL arst_rd_count4: got %0d required 0", rd_count4); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b required 0", busy); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL arst_rd_en: got %b required 0", fifo_rd_en); end
    exp_q.delete();
    dcnt = 0;
    wr_ptr = rd_ptr;
    @(posedge clk); @(posedge clk); #1;
    for (int i = 0; i < 17; i++) push_word(8'($urandom));
    rd_rst = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: got busy required idle"); end
    checks++; if (rd_count4 !== 4'd1) begin errors++; $display("FAIL wrap_rd_count4: got %0d required 1", rd_count4); end
    checks++; if (rd_count !== 16'd17) begin errors++; $display("FAIL wrap_rd_count: got %0d required 17", rd_count); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_empty_boundary();
    test_flush();
    test_random();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion required finish within time limit");
    $fatal(1);
  end

endmodule
